// File: rtl/capture_dump_if.sv
// Transmit byte stream between the capture dump engine and the host transmitter.
//
// Handshake: the master raises tx_vld with tx_data and holds both unchanged
// until a clock edge where tx_vld && tx_rdy. That edge transfers exactly one
// byte. tx_vld never drops without a transfer. The slave may drive tx_rdy
// freely, and tx_rdy may depend combinationally on nothing from this interface.
//
// Signals:
//   tx_data  master->slave  byte being offered
//   tx_vld   master->slave  tx_data is valid
//   tx_rdy   slave->master  slave accepts the byte on this edge when tx_vld=1
interface capture_dump_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_vld;
  logic              tx_rdy;

  modport master (output tx_data, output tx_vld, input tx_rdy);
  modport slave  (input tx_data, input tx_vld, output tx_rdy);
endinterface

// File: rtl/capture_dump.sv
// capture_dump: read side of the ADC capture engine. A dump request reads one
// channel's circular capture RAM, starting at the oldest sample, and streams
// every sample as one byte over the tx interface. The transfer finishes with a
// one-cycle dump_fin / clr_cap_done pulse.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   dump          request pulse, only looked at in IDLE
//   ch_sel        channel 0..2 (3 = invalid, finishes with no reads)
//   start_addr    address of the oldest sample
//   rd_en/rd_addr RAM read strobe and address, one read per sample
//   ch_en         one-hot RAM select of the latched channel, 0 when idle
//   rd_data       RAM read data, valid RD_LAT cycles after rd_en
//   tx            byte stream to the transmitter (master side)
//   dump_busy     high in every state but IDLE
//   dump_fin      one-cycle completion pulse
//   clr_cap_done  one-cycle pulse together with dump_fin
//   state_dbg     current FSM state encoding
module capture_dump #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dump,
  input  logic [1:0]        ch_sel,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [2:0]        ch_en,
  input  logic [DATA_W-1:0] rd_data,
  capture_dump_if.master    tx,
  output logic              dump_busy,
  output logic              dump_fin,
  output logic              clr_cap_done,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } state_e;

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);
  // Count of the final sample of a dump (2**ADDR_W - 1).
  localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [1:0]          ch_q, ch_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [DATA_W-1:0]   txd_q, txd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      start_q <= '0;
      lat_q   <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      start_q <= start_d;
      lat_q   <= lat_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    start_d = start_q;
    lat_d   = lat_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        if (dump) begin
          ch_d    = ch_sel;
          start_d = start_addr;
          cnt_d   = '0;
          state_d = (ch_sel == 2'd3) ? FIN : READ;
        end
      end
      READ: begin
        lat_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // The last WAIT cycle is the one in which rd_data is valid.
        if (lat_q == LAT_LAST) begin
          txd_d   = rd_data;
          state_d = SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      SEND: begin
        if (tx.tx_rdy) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_LAST) ? FIN : READ;
        end
      end
      FIN: begin
        // A dump pulse seen here is deliberately dropped.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address arithmetic wraps naturally modulo the RAM depth.
  assign rd_en   = (state_q == READ);
  assign rd_addr = rd_en ? (start_q + cnt_q[ADDR_W-1:0]) : '0;

  always_comb begin
    ch_en = 3'b000;
    if (state_q != IDLE) begin
      case (ch_q)
        2'd0:    ch_en = 3'b001;
        2'd1:    ch_en = 3'b010;
        2'd2:    ch_en = 3'b100;
        default: ch_en = 3'b000;
      endcase
    end
  end

  assign tx.tx_vld    = (state_q == SEND);
  assign tx.tx_data   = txd_q;
  assign dump_busy    = (state_q != IDLE);
  assign dump_fin     = (state_q == FIN);
  assign clr_cap_done = (state_q == FIN);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_capture_dump.sv
module tb_capture_dump;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dump;
  logic [1:0]        ch_sel;
  logic [ADDR_W-1:0] start_addr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        ch_en;
  logic [DATA_W-1:0] rd_data;
  logic              dump_busy;
  logic              dump_fin;
  logic              clr_cap_done;
  logic [2:0]        state_dbg;

  capture_dump_if #(.DATA_W(DATA_W)) tx_if ();

  capture_dump #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump         (dump),
    .ch_sel       (ch_sel),
    .start_addr   (start_addr),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .ch_en        (ch_en),
    .rd_data      (rd_data),
    .tx           (tx_if),
    .dump_busy    (dump_busy),
    .dump_fin     (dump_fin),
    .clr_cap_done (clr_cap_done),
    .state_dbg    (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Three capture RAMs with one cycle read latency, muxed by ch_en.
  logic [7:0] ram [3][DEPTH];
  always @(posedge clk) begin
    if (rd_en) begin
      case (ch_en)
        3'b001:  rd_data <= ram[0][rd_addr];
        3'b010:  rd_data <= ram[1][rd_addr];
        3'b100:  rd_data <= ram[2][rd_addr];
        default: rd_data <= 8'h00;
      endcase
    end
  end

  // Scoreboard and observations
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [ADDR_W-1:0] addr_q[$];
  int   fin_cnt, clr_err, first_vld_cyc, fin_cyc, stall_err, chen_changes, rd_cnt;
  logic [2:0] chen_first;
  bit   busy_after, timed_out;

  // Driver tasks
  task automatic start_dump(input logic [1:0] ch, input logic [ADDR_W-1:0] sa, input bit hold);
    @(posedge clk); #1;
    ch_sel = ch; start_addr = sa; dump = 1'b1;
    @(posedge clk); #1;   // this edge samples the request
    if (!hold) dump = 1'b0;
  endtask

  // Steps the clock after a dump request and records what the DUT does.
  // cyc counts edges after the sampling edge; sampled on the falling edge.
  task automatic run_stream(input bit rand_rdy, input bit poke, input int stop_after);
    logic [DATA_W-1:0] held;
    bit stalled, done;
    stalled = 0; done = 0; held = '0;
    got_q.delete(); addr_q.delete();
    fin_cnt = 0; clr_err = 0; first_vld_cyc = -1; fin_cyc = -1;
    stall_err = 0; chen_changes = 0; rd_cnt = 0; chen_first = 3'b000;
    busy_after = 1'b1; timed_out = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      if (done) begin
        busy_after = dump_busy;
        return;
      end
      if (cyc == 0) chen_first = ch_en;
      else if (dump_busy && ch_en !== chen_first) chen_changes++;
      if (rd_en) begin
        rd_cnt++;
        addr_q.push_back(rd_addr);
      end
      if (stalled && (!tx_if.tx_vld || tx_if.tx_data !== held)) stall_err++;
      stalled = tx_if.tx_vld && !tx_if.tx_rdy;
      held    = tx_if.tx_data;
      if (tx_if.tx_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (tx_if.tx_vld && tx_if.tx_rdy) got_q.push_back(tx_if.tx_data);
      if (dump_fin) begin
        fin_cnt++;
        if (fin_cyc < 0) fin_cyc = cyc;
        done = 1;
      end
      if (dump_fin !== clr_cap_done) clr_err++;
      if (stop_after > 0 && got_q.size() == stop_after) return;
      @(posedge clk); #1;
      if (rand_rdy) tx_if.tx_rdy = 1'($urandom_range(0, 1));
      if (poke && !done) begin
        dump       = ((cyc % 97) == 5);
        ch_sel     = 2'(cyc);
        start_addr = ADDR_W'($urandom);
      end else begin
        dump = 1'b0;
      end
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; dump = 1'b0; ch_sel = '0; start_addr = '0; tx_if.tx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({rd_en, rd_addr, ch_en, tx_if.tx_vld, tx_if.tx_data, dump_busy, dump_fin,
         clr_cap_done, state_dbg} !== '0) begin
      err_cnt++;
      $display("FAIL reset_outputs: rd_en=%b rd_addr=%h ch_en=%b vld=%b data=%h busy=%b fin=%b clr=%b st=%0d required all 0",
               rd_en, rd_addr, ch_en, tx_if.tx_vld, tx_if.tx_data, dump_busy, dump_fin, clr_cap_done, state_dbg);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (dump_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_idle_busy: got %b required 0", dump_busy);
    end
  endtask

  task automatic test_linear;
    for (int i = 0; i < DEPTH; i++) ram[0][i] = 8'(i);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[0][i]);
    tx_if.tx_rdy = 1'b1;
    start_dump(2'd0, 9'h000, 0);
    run_stream(0, 0, 0);
    vec_cnt++;
    if (timed_out) begin err_cnt++; $display("FAIL linear_timeout: no dump_fin within budget"); end
    // tx_vld rises two edges after the sampling edge (third cycle after dump).
    vec_cnt++;
    if (first_vld_cyc !== 2) begin err_cnt++; $display("FAIL linear_latency: got %0d required 2", first_vld_cyc); end
    vec_cnt++;
    if (fin_cnt !== 1 || clr_err !== 0) begin
      err_cnt++; $display("FAIL linear_fin: fin_cycles=%0d clr_diff=%0d required 1/0", fin_cnt, clr_err);
    end
    vec_cnt++;
    if (busy_after !== 1'b0) begin err_cnt++; $display("FAIL linear_busy_after: got %b required 0", busy_after); end
    vec_cnt++;
    if (got_q.size() !== DEPTH) begin err_cnt++; $display("FAIL linear_count: got %0d required %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vec_cnt++;
      if (g !== exp_q[i]) begin err_cnt++; $display("FAIL linear_byte[%0d]: got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_wrap;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[1][(9'h1FE + i) % DEPTH]);
    tx_if.tx_rdy = 1'b1;
    start_dump(2'd1, 9'h1FE, 0);
    run_stream(0, 0, 0);
    vec_cnt++;
    if (timed_out) begin err_cnt++; $display("FAIL wrap_timeout: no dump_fin within budget"); end
    vec_cnt++;
    if (addr_q.size() !== DEPTH) begin err_cnt++; $display("FAIL wrap_reads: got %0d required %0d", addr_q.size(), DEPTH); end
    else begin
      vec_cnt++;
      if (addr_q[0] !== 9'h1FE || addr_q[1] !== 9'h1FF || addr_q[2] !== 9'h000 || addr_q[DEPTH-1] !== 9'h1FD) begin
        err_cnt++;
        $display("FAIL wrap_addr: got %h %h %h .. %h required 1fe 1ff 000 .. 1fd", addr_q[0], addr_q[1], addr_q[2], addr_q[DEPTH-1]);
      end
    end
    vec_cnt++;
    if (chen_first !== 3'b010 || chen_changes !== 0) begin
      err_cnt++; $display("FAIL wrap_ch_en: got %b changes=%0d required 010 changes=0", chen_first, chen_changes);
    end
    vec_cnt++;
    if (got_q.size() !== DEPTH) begin err_cnt++; $display("FAIL wrap_count: got %0d required %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vec_cnt++;
      if (g !== exp_q[i]) begin err_cnt++; $display("FAIL wrap_byte[%0d]: got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_backpressure;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[2][(9'h0A5 + i) % DEPTH]);
    tx_if.tx_rdy = 1'b0;
    start_dump(2'd2, 9'h0A5, 0);
    run_stream(1, 0, 0);
    tx_if.tx_rdy = 1'b1;
    vec_cnt++;
    if (timed_out) begin err_cnt++; $display("FAIL bp_timeout: no dump_fin within budget"); end
    vec_cnt++;
    if (stall_err !== 0) begin err_cnt++; $display("FAIL bp_stable: %0d unstable stall cycles, required 0", stall_err); end
    vec_cnt++;
    if (got_q.size() !== DEPTH) begin err_cnt++; $display("FAIL bp_count: got %0d required %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vec_cnt++;
      if (g !== exp_q[i]) begin err_cnt++; $display("FAIL bp_byte[%0d]: got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_ignore_dump;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[1][(9'h040 + i) % DEPTH]);
    tx_if.tx_rdy = 1'b1;
    start_dump(2'd1, 9'h040, 0);
    run_stream(0, 1, 0);
    dump = 1'b0;
    vec_cnt++;
    if (timed_out) begin err_cnt++; $display("FAIL ignore_timeout: no dump_fin within budget"); end
    vec_cnt++;
    if (chen_first !== 3'b010 || chen_changes !== 0) begin
      err_cnt++; $display("FAIL ignore_ch_en: got %b changes=%0d required 010 changes=0", chen_first, chen_changes);
    end
    vec_cnt++;
    if (got_q.size() !== DEPTH || fin_cnt !== 1) begin
      err_cnt++; $display("FAIL ignore_count: got %0d bytes %0d fin required %0d/1", got_q.size(), fin_cnt, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vec_cnt++;
      if (g !== exp_q[i]) begin err_cnt++; $display("FAIL ignore_byte[%0d]: got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_invalid_ch;
    // dump stays high through the FIN cycle; that second request must be dropped.
    start_dump(2'd3, 9'h055, 1);
    run_stream(0, 0, 0);
    dump = 1'b0;
    vec_cnt++;
    if (fin_cyc !== 0 || fin_cnt !== 1 || clr_err !== 0) begin
      err_cnt++; $display("FAIL inv_fin: at cyc %0d count %0d clr_diff %0d required 0/1/0", fin_cyc, fin_cnt, clr_err);
    end
    vec_cnt++;
    if (rd_cnt !== 0 || first_vld_cyc !== -1 || chen_first !== 3'b000) begin
      err_cnt++; $display("FAIL inv_activity: reads=%0d vld_cyc=%0d ch_en=%b required 0/-1/000", rd_cnt, first_vld_cyc, chen_first);
    end
    vec_cnt++;
    if (busy_after !== 1'b0) begin err_cnt++; $display("FAIL inv_fin_dump_ignored: busy=%b required 0", busy_after); end
  endtask

  task automatic test_reset_abort;
    int fin_seen;
    tx_if.tx_rdy = 1'b1;
    start_dump(2'd0, 9'h100, 0);
    run_stream(0, 0, 100);
    @(posedge clk); #1;          // byte 100 is accepted on this edge
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({rd_en, rd_addr, ch_en, tx_if.tx_vld, tx_if.tx_data, dump_busy, dump_fin,
         clr_cap_done, state_dbg} !== '0) begin
      err_cnt++;
      $display("FAIL abort_outputs: rd_en=%b rd_addr=%h ch_en=%b vld=%b data=%h busy=%b fin=%b st=%0d required all 0",
               rd_en, rd_addr, ch_en, tx_if.tx_vld, tx_if.tx_data, dump_busy, dump_fin, state_dbg);
    end
    fin_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (dump_fin) fin_seen++;
    end
    vec_cnt++;
    if (fin_seen !== 0 || got_q.size() !== 100) begin
      err_cnt++; $display("FAIL abort_no_fin: fin=%0d bytes=%0d required 0/100", fin_seen, got_q.size());
    end
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(ram[2][(9'h1F0 + i) % DEPTH]);
    start_dump(2'd2, 9'h1F0, 0);
    run_stream(0, 0, 0);
    vec_cnt++;
    if (timed_out || fin_cnt !== 1 || got_q.size() !== DEPTH) begin
      err_cnt++; $display("FAIL abort_redump: timeout=%b fin=%0d bytes=%0d required 0/1/%0d", timed_out, fin_cnt, got_q.size(), DEPTH);
    end
    vec_cnt++;
    if (chen_first !== 3'b100) begin err_cnt++; $display("FAIL abort_ch_en: got %b required 100", chen_first); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      vec_cnt++;
      if (g !== exp_q[i]) begin err_cnt++; $display("FAIL abort_byte[%0d]: got %h required %h", i, g, exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[0][i] = 8'(i);
      ram[1][i] = 8'(i) ^ 8'hA5;
      ram[2][i] = 8'(i * 7 + 3);
    end
    test_reset();
    test_linear();
    test_wrap();
    test_backpressure();
    test_ignore_dump();
    test_invalid_ch();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
